stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEB_SAMPLES, default 4: consecutive equal 400 Hz samples needed to accept a button level change (range 2..15).
REQ-002 sclk  in  1  system clock (100 MHz); all state changes on posedge sclk.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 clk_1hz, clk_2hz, clk_400hz  in  1 each  square-wave rates from the divider, treated as data, never as clocks.
REQ-005 btn_pause, btn_reset  in  1 each  raw asynchronous push-buttons, high = pressed.
REQ-006 sw_adj, sw_sel  in  1 each  raw slide switches: adjust mode; field select (0 = seconds, 1 = minutes).
REQ-007 min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD time value.
REQ-008 digit  out  4  BCD value of the currently scanned digit.
REQ-009 an  out  4  active-low one-hot anode select.
REQ-010 running  out  1  high only in state RUN.

Function
REQ-011 Rate inputs, buttons and switches SHALL each pass through a 2-flop synchronizer before use.
REQ-012 A rising edge on each synchronized rate input SHALL produce a 1-sclk pulse: tick_1, tick_2 or tick_400.
REQ-013 Debounce: each synchronized button SHALL be sampled on tick_400. The debounced level changes only after DEB_SAMPLES consecutive equal samples.
REQ-014 A debounced 0->1 transition SHALL produce a 1-sclk press event (pause_ev or reset_ev). Holding the button SHALL produce no further events.
REQ-015 FSM states: IDLE, RUN, PAUSE, ADJUST.
REQ-016 Transitions on pause_ev: IDLE->RUN, RUN->PAUSE, PAUSE->RUN. pause_ev SHALL be ignored in ADJUST.
REQ-017 sw_adj=1 SHALL force ADJUST from IDLE, RUN or PAUSE on the next cycle. sw_adj=0 while in ADJUST SHALL go to PAUSE.
REQ-018 reset_ev SHALL clear all four digits to 0 in any state. Next state: IDLE if sw_adj=0, ADJUST if sw_adj=1.
REQ-019 RUN counting: each tick_1 SHALL increment MM:SS in BCD.
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 carries into min_ones.
  - min_ones 9->0 carries into min_tens.
  - 59:59 wraps to 00:00.
REQ-020 tick_1 SHALL be ignored in IDLE, PAUSE and ADJUST. No tick is queued for later.
REQ-021 ADJUST: each tick_2 SHALL increment the field chosen by sw_sel by one. 59 wraps to 00 with no carry into the other field.
REQ-022 blink SHALL toggle on each tick_2 in ADJUST and SHALL be 0 in every other state.
REQ-023 Scan index (2 bits) SHALL advance on each tick_400.
  - Index 0/1/2/3 selects sec_ones/sec_tens/min_ones/min_tens.
  - an = 1110/1101/1011/0111 for index 0/1/2/3.
  - digit = the selected BCD value.
REQ-024 In ADJUST with blink=1, an SHALL read 1111 while the selected field's digits are scanned. digit is unaffected.
REQ-025 Simultaneous events in one cycle:
  - reset_ev beats pause_ev and any tick.
  - sw_adj entry beats pause_ev.
  - tick_1 in the same cycle as the RUN->PAUSE transition still increments (state evaluated before update).
REQ-026 Digit outputs, digit, an and running SHALL be registered. running SHALL assert on the cycle after the RUN transition.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for sclk, set all of the following:
  - state IDLE; all four digits 0.
  - scan index 0, an=1110, digit=0.
  - running=0, blink=0.
  - synchronizer, edge, debounce and event registers 0.
REQ-028 Asserting rst mid-count SHALL abort operation with no partial increment. After deassertion, operation resumes from IDLE at 00:00.

Verification
REQ-029 Clean pause press (held > DEB_SAMPLES x 2.5 ms) from IDLE, then 3 rising edges on clk_1hz -> running=1, display 00:03.
REQ-030 Preload 59:58 in RUN, then 2 tick_1 -> 59:59, then 00:00. Preload 09:59, then 1 tick_1 -> 10:00.
REQ-031 Bouncy btn_pause toggling every 1 ms for 10 ms, then stable high -> exactly one pause_ev; state RUN->PAUSE.
REQ-032 sw_adj=1, sw_sel=1 at 58:30, then 3 tick_2 -> 01:30 with seconds untouched. Minute anodes read 1111 on alternate blink phases. sw_adj=0 -> PAUSE.
REQ-033 pause_ev and reset_ev in the same cycle while RUN at 12:34 -> 00:00, IDLE, running=0.
REQ-034 Assert rst asynchronously between sclk edges during RUN -> outputs reach their reset values before the next sclk edge. After release, 8 tick_400 -> an cycles 1110, 1101, 1011, 0111 twice.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bus.
//   master: drives the divider rates, raw buttons and raw switches,
//           and reads back the BCD time, scan digit/anodes and running flag.
//   slave : the stopwatch controller itself.
interface stopwatch_ctrl_if;
  logic       clk_1hz, clk_2hz, clk_400hz;
  logic       btn_pause, btn_reset;
  logic       sw_adj, sw_sel;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [3:0] digit, an;
  logic       running;

  modport master (
    output clk_1hz, clk_2hz, clk_400hz, btn_pause, btn_reset, sw_adj, sw_sel,
    input  min_tens, min_ones, sec_tens, sec_ones, digit, an, running
  );
  modport slave (
    input  clk_1hz, clk_2hz, clk_400hz, btn_pause, btn_reset, sw_adj, sw_sel,
    output min_tens, min_ones, sec_tens, sec_ones, digit, an, running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: MM:SS BCD counter with pause/reset buttons, a
// field-adjust mode and a 4-digit multiplexed display scan.
//   sclk : 100 MHz system clock, only clock in the block
//   rst  : asynchronous active-high reset
//   bus  : stopwatch_ctrl_if.slave -- rate inputs (sampled as data), raw
//          buttons/switches in; BCD digits, scanned digit, active-low
//          anodes and running flag out (all registered).

// Per-button debouncer: accepts a level change after DEB_SAMPLES
// consecutive samples disagreeing with the current level; emits a
// 1-sclk press pulse on an accepted 0->1 change.
module stopwatch_debounce #(
  parameter int DEB_SAMPLES = 4
) (
  input  logic sclk,
  input  logic rst,
  input  logic smp,
  input  logic din,
  output logic press
);
  logic       level;
  logic [3:0] cnt;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (smp) begin
        if (din == level) cnt <= '0;
        else if (cnt == 4'(DEB_SAMPLES - 1)) begin
          level <= din;
          cnt   <= '0;
          press <= din;
        end else cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int DEB_SAMPLES = 4
) (
  input logic           sclk,
  input logic           rst,
  stopwatch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ADJUST} state_t;

  // {sel, adj, btn_reset, btn_pause, r400, r2, r1}
  logic [6:0] raw, s1, s2;
  logic [2:0] rate_q;
  logic [2:0] tick;
  logic [1:0] press;
  logic       tick_1, tick_2, tick_400, pause_ev, reset_ev, adj_s, sel_s;

  state_t     state, state_n;
  logic [3:0] mt, mo, st, so;
  logic [3:0] an_q, digit_q;
  logic [1:0] idx;
  logic       blink, running_q;

  assign raw = {bus.sw_sel, bus.sw_adj, bus.btn_reset, bus.btn_pause,
                bus.clk_400hz, bus.clk_2hz, bus.clk_1hz};

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      rate_q <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      rate_q <= s2[2:0];
    end
  end

  assign tick     = s2[2:0] & ~rate_q;
  assign tick_1   = tick[0];
  assign tick_2   = tick[1];
  assign tick_400 = tick[2];
  assign adj_s    = s2[5];
  assign sel_s    = s2[6];

  genvar g;
  for (g = 0; g < 2; g++) begin : g_deb
    stopwatch_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
      .sclk (sclk),
      .rst  (rst),
      .smp  (tick_400),
      .din  (s2[3 + g]),
      .press(press[g])
    );
  end

  assign pause_ev = press[0];
  assign reset_ev = press[1];

  // Priority: reset_ev, then adjust-switch entry/exit, then pause_ev.
  always_comb begin
    state_n = state;
    if (reset_ev) state_n = adj_s ? ADJUST : IDLE;
    else begin
      case (state)
        IDLE:    if (adj_s) state_n = ADJUST; else if (pause_ev) state_n = RUN;
        RUN:     if (adj_s) state_n = ADJUST; else if (pause_ev) state_n = PAUSE;
        PAUSE:   if (adj_s) state_n = ADJUST; else if (pause_ev) state_n = RUN;
        ADJUST:  if (!adj_s) state_n = PAUSE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Counting decisions use the current state, so a tick_1 landing on the
  // RUN->PAUSE edge still counts.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      running_q <= 1'b0;
      {mt, mo, st, so} <= '0;
      blink     <= 1'b0;
      idx       <= '0;
      an_q      <= 4'b1110;
      digit_q   <= '0;
    end else begin
      state     <= state_n;
      running_q <= (state_n == RUN);

      if (reset_ev) {mt, mo, st, so} <= '0;
      else if (state == RUN && tick_1) begin
        if (so != 4'd9) so <= so + 4'd1;
        else begin
          so <= '0;
          if (st != 4'd5) st <= st + 4'd1;
          else begin
            st <= '0;
            if (mo != 4'd9) mo <= mo + 4'd1;
            else begin
              mo <= '0;
              mt <= (mt == 4'd5) ? 4'd0 : mt + 4'd1;
            end
          end
        end
      end else if (state == ADJUST && tick_2) begin
        // field wraps 59->00 on its own, no carry across fields
        if (sel_s) begin
          if (mo != 4'd9) mo <= mo + 4'd1;
          else begin
            mo <= '0;
            mt <= (mt == 4'd5) ? 4'd0 : mt + 4'd1;
          end
        end else begin
          if (so != 4'd9) so <= so + 4'd1;
          else begin
            so <= '0;
            st <= (st == 4'd5) ? 4'd0 : st + 4'd1;
          end
        end
      end

      if (reset_ev || state_n != ADJUST) blink <= 1'b0;
      else if (state == ADJUST && tick_2) blink <= ~blink;

      if (tick_400) idx <= idx + 2'd1;

      case (idx)
        2'd0:    digit_q <= so;
        2'd1:    digit_q <= st;
        2'd2:    digit_q <= mo;
        default: digit_q <= mt;
      endcase
      // blink is only ever set in ADJUST; idx[1] picks the minutes pair
      an_q <= (blink && (idx[1] == sel_s)) ? 4'b1111 : ~(4'b0001 << idx);
    end
  end

  assign bus.min_tens = mt;
  assign bus.min_ones = mo;
  assign bus.sec_tens = st;
  assign bus.sec_ones = so;
  assign bus.digit    = digit_q;
  assign bus.an       = an_q;
  assign bus.running  = running_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: stimulus tasks drive the bus and advance a
// seconds-based reference model, pushing the expected display into a
// scoreboard queue; a separate monitor pops and compares on each request.
module tb_stopwatch_ctrl;
  localparam int DEB = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_ADJ = 3;

  logic sclk, rst;
  stopwatch_ctrl_if bus();

  stopwatch_ctrl #(.DEB_SAMPLES(DEB)) dut (.sclk(sclk), .rst(rst), .bus(bus));

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct {
    logic [3:0] mt, mo, st, so, dig, an;
    logic       run;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  event smp;
  int   checks = 0;
  int   errors = 0;

  // reference model: time as total seconds
  int m_t = 0, m_st = S_IDLE, m_scan = 0;
  bit m_blink = 0, m_adj = 0, m_sel = 0;

  task automatic chk(input string nm);
    exp_t e;
    int mm, ss, ix;
    mm = m_t / 60; ss = m_t % 60; ix = m_scan % 4;
    e.mt = 4'(mm / 10); e.mo = 4'(mm % 10);
    e.st = 4'(ss / 10); e.so = 4'(ss % 10);
    case (ix)
      0: e.dig = e.so;
      1: e.dig = e.st;
      2: e.dig = e.mo;
      default: e.dig = e.mt;
    endcase
    e.an  = (m_blink && m_st == S_ADJ && (ix / 2) == int'(m_sel)) ? 4'hF : ~(4'b0001 << ix);
    e.run = (m_st == S_RUN);
    e.nm  = nm;
    sbq.push_back(e);
    -> smp;
  endtask

  initial begin
    exp_t e;
    logic [24:0] act, want;
    forever begin
      @(smp);
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: sample requested with nothing expected");
      end else begin
        e    = sbq.pop_front();
        act  = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones, bus.digit, bus.an, bus.running};
        want = {e.mt, e.mo, e.st, e.so, e.dig, e.an, e.run};
        if (act !== want) begin
          errors++;
          $display("FAIL %s: got %h%h:%h%h dig=%h an=%b run=%b, want %h%h:%h%h dig=%h an=%b run=%b",
                   e.nm, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones, bus.digit,
                   bus.an, bus.running, e.mt, e.mo, e.st, e.so, e.dig, e.an, e.run);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic p1();
    bus.clk_1hz = 1'b1; cyc(4); bus.clk_1hz = 1'b0; cyc(4);
    if (m_st == S_RUN) m_t = (m_t + 1) % 3600;
  endtask

  task automatic p2();
    int mm, ss;
    bus.clk_2hz = 1'b1; cyc(4); bus.clk_2hz = 1'b0; cyc(4);
    if (m_st == S_ADJ) begin
      mm = m_t / 60; ss = m_t % 60;
      if (m_sel) mm = (mm + 1) % 60; else ss = (ss + 1) % 60;
      m_t = mm * 60 + ss;
      m_blink = ~m_blink;
    end
  endtask

  task automatic p400();
    bus.clk_400hz = 1'b1; cyc(4); bus.clk_400hz = 1'b0; cyc(4);
    m_scan++;
  endtask

  // clean press: held and released for more than DEB samples each
  task automatic press(input bit bp, input bit br);
    bus.btn_pause = bp; bus.btn_reset = br;
    repeat (DEB + 1) p400();
    bus.btn_pause = 1'b0; bus.btn_reset = 1'b0;
    repeat (DEB + 1) p400();
    if (br) begin
      m_t = 0; m_blink = 0;
      m_st = m_adj ? S_ADJ : S_IDLE;
    end else if (bp) begin
      case (m_st)
        S_IDLE:  m_st = S_RUN;
        S_RUN:   m_st = S_PAUSE;
        S_PAUSE: m_st = S_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic set_adj(input bit v);
    bus.sw_adj = v; cyc(6);
    if (v && m_st != S_ADJ) begin m_st = S_ADJ; m_blink = 0; end
    if (!v && m_st == S_ADJ) begin m_st = S_PAUSE; m_blink = 0; end
    m_adj = v;
  endtask

  task automatic set_sel(input bit v);
    bus.sw_sel = v; cyc(6);
    m_sel = v;
  endtask

  // load MM:SS through adjust mode; leaves the stopwatch in PAUSE
  task automatic preload(input int mm, input int ss);
    set_adj(1);
    press(0, 1);
    set_sel(1);
    repeat (mm) p2();
    set_sel(0);
    repeat (ss) p2();
    set_adj(0);
  endtask

  initial begin
    rst = 1'b1;
    bus.clk_1hz = 0; bus.clk_2hz = 0; bus.clk_400hz = 0;
    bus.btn_pause = 0; bus.btn_reset = 0; bus.sw_adj = 0; bus.sw_sel = 0;
    #1 chk("reset_state");
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("post_reset");

    // start from IDLE and count three seconds
    press(1, 0); chk("start_run");
    for (int i = 0; i < 3; i++) begin p1(); chk("count_up"); end

    // wrap at 59:59 and minute carry
    preload(59, 58); chk("preload_5958");
    press(1, 0);
    p1(); chk("to_5959");
    p1(); chk("wrap_0000");
    preload(9, 59);
    press(1, 0);
    p1(); chk("carry_1000");

    // bouncy pause button while running: exactly one event -> PAUSE
    for (int i = 0; i < 8; i++) begin
      bus.btn_pause = ~bus.btn_pause;
      p400();
    end
    press(1, 0); chk("bounce_pause");

    // minute adjust with blink, seconds untouched
    preload(58, 30);
    set_adj(1); set_sel(1); chk("adj_enter");
    for (int i = 0; i < 3; i++) begin
      p2();   chk("adj_tick2");
      p400(); chk("adj_scan_a");
      p400(); chk("adj_scan_b");
    end
    set_adj(0); chk("adj_exit_pause");

    // simultaneous pause and reset while running
    preload(12, 34);
    press(1, 0); chk("run_1234");
    press(1, 1); chk("reset_beats_pause");

    // randomized operation mix
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: p1();
        3, 4:    p2();
        5:       p400();
        6:       press(1, 0);
        7:       if ($urandom_range(0, 3) == 0) press(0, 1); else p1();
        8:       set_adj(~m_adj);
        default: set_sel(~m_sel);
      endcase
      chk("random_op");
    end

    // asynchronous reset mid-run, then scan restarts from index 0
    set_adj(0);
    preload(12, 0);
    press(1, 0);
    p1(); chk("run_before_rst");
    @(posedge sclk);
    #2 rst = 1'b1;
    m_t = 0; m_st = S_IDLE; m_blink = 0; m_scan = 0;
    #1 chk("async_rst");
    cyc(2);
    rst = 1'b0;
    cyc(2);
    for (int i = 0; i < 8; i++) begin p400(); chk("scan_after_rst"); end

    cyc(2);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
